// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants for the VGA scan generator and its renderers:
// default 640x480@60 Hz porch/sync widths, sync polarity constants, the
// coordinate width and a small window-decode helper.
// ----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int COORD_W     = 10;
    localparam int COUNT_W     = 16;
    localparam int COORD_LIMIT = 1 << COORD_W;

    // Default 640x480 @ 60 Hz timing, 25 MHz pixel clock.
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // Sync polarity: the value driven while the pulse is active.
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    localparam int SYNC_DELAY_MAX = 4;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic hs;
        logic vs;
    } sync_t;

    // True when lo <= v < hi.
    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// ----------------------------------------------------------------------------
// vga_timing_gen_if
// Scan-timing bundle from the generator to the pixel renderers and the
// monitor connector.
//   DrawX/DrawY  current scan coordinate
//   blank        1 = visible pixel
//   hs/vs        monitor syncs, already delayed to match renderer pipeline
//   frame_start  one-cycle pulse at (0,0)
//   frame_count  completed-frame counter
// master: the timing generator; slave: renderers / consumers.
// ----------------------------------------------------------------------------
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    coord_t             DrawX;
    coord_t             DrawY;
    logic               blank;
    logic               hs;
    logic               vs;
    logic               frame_start;
    logic [COUNT_W-1:0] frame_count;

    modport master (
        output DrawX, DrawY, blank, hs, vs, frame_start, frame_count
    );

    modport slave (
        input  DrawX, DrawY, blank, hs, vs, frame_start, frame_count
    );

endinterface

// File: rtl/sync_delay_line.sv
// ----------------------------------------------------------------------------
// sync_delay_line
// DEPTH x WIDTH shift register, asynchronously reset to RESET_VAL.
// DEPTH = 0 degenerates to a wire.
//   vga_clk  shift clock
//   reset_n  asynchronous active-low reset
//   d        input word
//   q        d delayed by DEPTH clocks
// ----------------------------------------------------------------------------
module sync_delay_line #(
    parameter int               DEPTH     = 1,
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, vga_clk, reset_n};
        assign q = d;
    end else begin : g_chain
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
                // NOTE: every stage is reset, not just the output one; these
                // are a few flops, not a RAM, and a stale stage would emit a
                // spurious sync pulse to the monitor right after reset.
                for (int i = 0; i < DEPTH; i++) begin
                    stage[i] <= RESET_VAL;
                end
            end else begin
                // NOTE: non-blocking assignments make the loop order
                // irrelevant; every stage samples its neighbour's old value.
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// Scan-coordinate and sync generator for the pixel renderers.
//   vga_clk  pixel clock
//   reset_n  asynchronous active-low reset
//   vga      (master) DrawX, DrawY, blank, hs, vs, frame_start, frame_count
// DrawX/DrawY/blank/frame_start are current-cycle values; hs/vs are delayed
// by SYNC_DELAY clocks so they line up with the renderers' registered RGB.
// ----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter bit HS_POL     = SYNC_ACTIVE_LOW,
    parameter bit VS_POL     = SYNC_ACTIVE_LOW,
    parameter int SYNC_DELAY = 1
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_size_check
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
    end

    if (SYNC_DELAY < 0 || SYNC_DELAY > SYNC_DELAY_MAX) begin : g_delay_check
        $error("vga_timing_gen: SYNC_DELAY must be 0..4");
    end

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    logic               running;
    coord_t             draw_x;
    coord_t             draw_y;
    logic [COUNT_W-1:0] frame_cnt;
    logic               frame_start;
    sync_t              sync_raw;
    sync_t              sync_dly;

    // running gives one idle cycle after reset release so the first
    // frame_start is seen with all counters at a clean zero.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            running   <= 1'b0;
            draw_x    <= '0;
            draw_y    <= '0;
            frame_cnt <= '0;
        end else begin
            running <= 1'b1;
            if (running) begin
                if (draw_x == H_LAST) begin
                    draw_x <= '0;
                    draw_y <= (draw_y == V_LAST) ? '0 : draw_y + coord_t'(1);
                end else begin
                    draw_x <= draw_x + coord_t'(1);
                end
                if (frame_start) begin
                    frame_cnt <= frame_cnt + COUNT_W'(1);
                end
            end
        end
    end

    assign frame_start = running && (draw_x == '0) && (draw_y == '0);

    always_comb begin
        // NOTE: both fields get their inactive level first, so every path
        // assigns them and no latch can be inferred.
        sync_raw.hs = ~HS_POL;
        sync_raw.vs = ~VS_POL;
        if (running && in_window(draw_x, HS_START, HS_END)) begin
            sync_raw.hs = HS_POL;
        end
        if (running && in_window(draw_y, VS_START, VS_END)) begin
            sync_raw.vs = VS_POL;
        end
    end

    sync_delay_line #(
        .DEPTH     (SYNC_DELAY),
        .WIDTH     (2),
        .RESET_VAL ({~HS_POL, ~VS_POL})
    ) u_sync_dly (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .d       (sync_raw),
        .q       (sync_dly)
    );

    assign vga.DrawX       = draw_x;
    assign vga.DrawY       = draw_y;
    assign vga.blank       = running && (draw_x < H_VIS) && (draw_y < V_VIS);
    assign vga.hs          = sync_dly.hs;
    assign vga.vs          = sync_dly.vs;
    assign vga.frame_start = frame_start;
    assign vga.frame_count = frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
// dut_d: default timing.  dut_z: SYNC_DELAY=0, HS_POL=1.  dut_t: SYNC_DELAY=3.
// dut_s: shrunken timing (24 x 15) for whole-frame, mid-frame reset and
// frame_count wrap sequences. Outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic vga_clk;
    logic rst_n_a;
    logic rst_n_b;

    int n_vec = 0;
    int n_err = 0;

    vga_timing_gen_if if_d ();
    vga_timing_gen_if if_z ();
    vga_timing_gen_if if_t ();
    vga_timing_gen_if if_s ();

    vga_timing_gen dut_d (.vga_clk(vga_clk), .reset_n(rst_n_a), .vga(if_d));

    vga_timing_gen #(.SYNC_DELAY(0), .HS_POL(1'b1)) dut_z (
        .vga_clk(vga_clk), .reset_n(rst_n_a), .vga(if_z));

    vga_timing_gen #(.SYNC_DELAY(3)) dut_t (
        .vga_clk(vga_clk), .reset_n(rst_n_a), .vga(if_t));

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_s (.vga_clk(vga_clk), .reset_n(rst_n_b), .vga(if_s));

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One row = expected outputs at the t-th falling edge after release.
    typedef struct {
        int   t;
        int   x;
        int   y;
        logic blank;
        logic hs;
        logic vs;
        logic fs;
        int   fc;
        logic hs_z;
        logic hs_t;
    } vec_t;

    vec_t vecs[$];

    int t_now;
    int k, period, vs_low, blank_hi, bad_blank, max_x, max_y, last_y, found;
    int hs_d_low, hs_z_high, hs_t_low, blank_cnt;

    initial begin
        //                t     x    y  bl hs vs fs fc hz ht
        vecs.push_back('{   1,   0,  0, 0, 1, 1, 0, 0, 0, 1});
        vecs.push_back('{   2,   0,  0, 1, 1, 1, 1, 0, 0, 1});
        vecs.push_back('{   3,   1,  0, 1, 1, 1, 0, 1, 0, 1});
        vecs.push_back('{ 641, 639,  0, 1, 1, 1, 0, 1, 0, 1});
        vecs.push_back('{ 642, 640,  0, 0, 1, 1, 0, 1, 0, 1});
        vecs.push_back('{ 658, 656,  0, 0, 1, 1, 0, 1, 1, 1});
        vecs.push_back('{ 659, 657,  0, 0, 0, 1, 0, 1, 1, 1});
        vecs.push_back('{ 660, 658,  0, 0, 0, 1, 0, 1, 1, 1});
        vecs.push_back('{ 661, 659,  0, 0, 0, 1, 0, 1, 1, 0});
        vecs.push_back('{ 753, 751,  0, 0, 0, 1, 0, 1, 1, 0});
        vecs.push_back('{ 754, 752,  0, 0, 0, 1, 0, 1, 0, 0});
        vecs.push_back('{ 755, 753,  0, 0, 1, 1, 0, 1, 0, 0});
        vecs.push_back('{ 756, 754,  0, 0, 1, 1, 0, 1, 0, 0});
        vecs.push_back('{ 757, 755,  0, 0, 1, 1, 0, 1, 0, 1});
        vecs.push_back('{ 801, 799,  0, 0, 1, 1, 0, 1, 0, 1});
        vecs.push_back('{ 802,   0,  1, 1, 1, 1, 0, 1, 0, 1});
        vecs.push_back('{1602,   0,  2, 1, 1, 1, 0, 1, 0, 1});

        rst_n_a = 1'b0;
        rst_n_b = 1'b0;

        // ---- reset state ----
        repeat (5) @(negedge vga_clk);
        check("rst DrawX", if_d.DrawX, 0);
        check("rst DrawY", if_d.DrawY, 0);
        check("rst blank", if_d.blank, 0);
        check("rst hs", if_d.hs, 1);
        check("rst vs", if_d.vs, 1);
        check("rst frame_start", if_d.frame_start, 0);
        check("rst frame_count", if_d.frame_count, 0);
        check("rst hs_z", if_z.hs, 0);
        check("rst hs_t", if_t.hs, 1);

        // ---- release and table-driven first lines ----
        @(posedge vga_clk);
        #1 rst_n_a = 1'b1;
        t_now = 0;
        foreach (vecs[i]) begin
            while (t_now < vecs[i].t) begin
                @(negedge vga_clk);
                t_now++;
            end
            check($sformatf("t%0d DrawX", vecs[i].t), if_d.DrawX, vecs[i].x);
            check($sformatf("t%0d DrawY", vecs[i].t), if_d.DrawY, vecs[i].y);
            check($sformatf("t%0d blank", vecs[i].t), if_d.blank, vecs[i].blank);
            check($sformatf("t%0d hs", vecs[i].t), if_d.hs, vecs[i].hs);
            check($sformatf("t%0d vs", vecs[i].t), if_d.vs, vecs[i].vs);
            check($sformatf("t%0d frame_start", vecs[i].t), if_d.frame_start, vecs[i].fs);
            check($sformatf("t%0d frame_count", vecs[i].t), if_d.frame_count, vecs[i].fc);
            check($sformatf("t%0d hs_z", vecs[i].t), if_z.hs, vecs[i].hs_z);
            check($sformatf("t%0d hs_t", vecs[i].t), if_t.hs, vecs[i].hs_t);
        end

        // ---- one full line (DrawY=2): pulse widths and visible width ----
        hs_d_low = 0; hs_z_high = 0; hs_t_low = 0; blank_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (if_d.hs == 1'b0) hs_d_low++;
            if (if_z.hs == 1'b1) hs_z_high++;
            if (if_t.hs == 1'b0) hs_t_low++;
            if (if_d.blank == 1'b1) blank_cnt++;
            @(negedge vga_clk);
        end
        check("line hs low cycles", hs_d_low, 96);
        check("line hs_z high cycles", hs_z_high, 96);
        check("line hs_t low cycles", hs_t_low, 96);
        check("line visible cycles", blank_cnt, 640);
        check("line end DrawX", if_d.DrawX, 0);
        check("line end DrawY", if_d.DrawY, 3);

        // ---- small-timing DUT: first pulse and a whole frame ----
        @(posedge vga_clk);
        #1 rst_n_b = 1'b1;
        k = 0;
        do begin
            @(negedge vga_clk);
            k++;
        end while (!if_s.frame_start && k < 10);
        check("s first frame_start cycle", k, 2);
        check("s first frame_count", if_s.frame_count, 0);

        period = 0; vs_low = 0; blank_hi = 0; bad_blank = 0;
        max_x = 0; max_y = 0; last_y = -1;
        do begin
            if (if_s.vs == 1'b0) vs_low++;
            if (if_s.blank) blank_hi++;
            if (if_s.DrawY >= 8 && if_s.blank) bad_blank++;
            if (int'(if_s.DrawX) > max_x) max_x = int'(if_s.DrawX);
            if (int'(if_s.DrawY) > max_y) max_y = int'(if_s.DrawY);
            last_y = int'(if_s.DrawY);
            @(negedge vga_clk);
            period++;
        end while (!if_s.frame_start && period < 1000);
        check("s frame period", period, 360);
        check("s vs low cycles", vs_low, 48);
        check("s visible cycles", blank_hi, 128);
        check("s blank in vblank", bad_blank, 0);
        check("s max DrawX", max_x, 23);
        check("s max DrawY", max_y, 14);
        check("s DrawY before wrap", last_y, 14);
        check("s DrawY after wrap", if_s.DrawY, 0);
        check("s frame_count at 2nd pulse", if_s.frame_count, 1);
        @(negedge vga_clk);
        check("s frame_count after 2nd pulse", if_s.frame_count, 2);

        // ---- mid-frame asynchronous reset ----
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge vga_clk);
            if (if_s.DrawX == 10 && if_s.DrawY == 5) found = 1;
        end
        check("s reached (10,5)", found, 1);
        check("s blank before reset", if_s.blank, 1);
        #2 rst_n_b = 1'b0;
        #1;
        check("mid rst DrawX", if_s.DrawX, 0);
        check("mid rst DrawY", if_s.DrawY, 0);
        check("mid rst blank", if_s.blank, 0);
        check("mid rst hs", if_s.hs, 1);
        check("mid rst vs", if_s.vs, 1);
        check("mid rst frame_start", if_s.frame_start, 0);
        check("mid rst frame_count", if_s.frame_count, 0);
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1 rst_n_b = 1'b1;
        @(negedge vga_clk);
        check("post rst cycle1 frame_start", if_s.frame_start, 0);
        @(negedge vga_clk);
        check("post rst cycle2 frame_start", if_s.frame_start, 1);
        check("post rst frame_count", if_s.frame_count, 0);

        // ---- frame_count wrap ----
        @(negedge vga_clk);
        check("pre-wrap frame_count", if_s.frame_count, 1);
        dut_s.frame_cnt = 16'hFFFF;
        #1;
        check("deposit frame_count", if_s.frame_count, 16'hFFFF);
        k = 0;
        do begin
            @(negedge vga_clk);
            k++;
        end while (!if_s.frame_start && k < 400);
        check("wrap pulse found", (k < 400) ? 1 : 0, 1);
        check("frame_count at wrap pulse", if_s.frame_count, 16'hFFFF);
        @(negedge vga_clk);
        check("frame_count wrapped", if_s.frame_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
